// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the program/data memory arbiter.
// Holds bus widths, port indices and the arbiter FSM state encoding.
package cpu_pkg;

    localparam int REGSIZE     = 8;
    localparam int MEMSIZE     = 16;
    localparam int PORT_CPU    = 0;
    localparam int PORT_LOADER = 1;

    typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } ARB_STATE_TYPE;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Two-requester memory bus: per-port request/write controls in, grant/completion pulses out.
// The master modport is the requester side and the slave modport is the arbiter side.
interface mem_arbiter_if;
    import cpu_pkg::*;

    logic [1:0]  REQ;
    logic [1:0]  WE;
    DEFAULT_TYPE ADDR0;
    DEFAULT_TYPE ADDR1;
    DEFAULT_TYPE WDATA0;
    DEFAULT_TYPE WDATA1;
    logic [1:0]  GNT;
    logic [1:0]  RVALID;
    DEFAULT_TYPE RDATA;
    logic        ERR;

    modport master (
        output REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1,
        input  GNT, RVALID, RDATA, ERR
    );

    modport slave (
        input  REQ, WE, ADDR0, ADDR1, WDATA0, WDATA1,
        output GNT, RVALID, RDATA, ERR
    );

endinterface

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: combinational two-way winner select; win is the index of the granted port.
// Define MEM_ARB_LOADER_PRIO_EN to give the loader port strict priority (last is then ignored).
module arb_rr2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);

`ifdef MEM_ARB_LOADER_PRIO_EN
    // Loader always wins a conflict, so the cpu port can starve while the loader streams.
    always_comb begin
        win = req[PORT_LOADER];
    end
`else
    // A lone request wins outright; on a tie the port that did not go last wins.
    always_comb begin
        win = req[PORT_LOADER];
        if (req == 2'b11) begin
            win = ~last;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the MEMSIZE x REGSIZE memory and serialises cpu/loader accesses
// through an IDLE -> ACCESS -> RESP sequence. MEM_ARB_LOADER_PRIO_EN selects loader priority.
// An in-range write answers with its write data on RDATA; out-of-range answers 0 with ERR.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int MEMSIZE = cpu_pkg::MEMSIZE,
    parameter int REGSIZE = cpu_pkg::REGSIZE
) (
    input logic          CLOCK,
    input logic          RESET_N,
    mem_arbiter_if.slave bus
);

    localparam int AW = $clog2(MEMSIZE);

    ARB_STATE_TYPE      state;
    ARB_STATE_TYPE      state_nxt;
    logic               win;
    logic               win_q;
    logic               last_q;
    logic               we_q;
    logic [REGSIZE-1:0] addr_q;
    logic [REGSIZE-1:0] wdata_q;
    logic [REGSIZE-1:0] rdata_q;
    logic               err_q;
    logic               in_range;
    logic [REGSIZE-1:0] mem [MEMSIZE];

    arb_rr2 u_arb (
        .req  (bus.REQ),
        .last (last_q),
        .win  (win)
    );

    // Any set bit above the index field means the address lies past the array; no wrap.
    assign in_range = (addr_q[REGSIZE-1:AW] == '0);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:   if (|bus.REQ) state_nxt = ARB_ACCESS;
            ARB_ACCESS: state_nxt = ARB_RESP;
            ARB_RESP:   state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.GNT    = '0;
        bus.RVALID = '0;
        bus.ERR    = 1'b0;
        unique case (state)
            ARB_ACCESS: bus.GNT = port_onehot(win_q);
            ARB_RESP: begin
                bus.RVALID = port_onehot(win_q);
                bus.ERR    = err_q;
            end
            default: ;
        endcase
    end

    assign bus.RDATA = rdata_q;

    // Request contents are frozen on leaving IDLE; requester changes after that are ignored.
    always_ff @(posedge CLOCK) begin
        if (state == ARB_IDLE && |bus.REQ) begin
            we_q    <= bus.WE[win];
            addr_q  <= win ? bus.ADDR1 : bus.ADDR0;
            wdata_q <= win ? bus.WDATA1 : bus.WDATA0;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ARB_IDLE && |bus.REQ) begin
                win_q  <= win;
                last_q <= win;
            end
            if (state == ARB_ACCESS) begin
                err_q <= ~in_range;
                if (!in_range) begin
                    rdata_q <= '0;
                end else if (we_q) begin
                    rdata_q <= wdata_q;
                end else begin
                    rdata_q <= mem[addr_q[AW-1:0]];
                end
            end
        end
    end

    // Reset forces the state out of ACCESS asynchronously, which cancels a pending write.
    always_ff @(posedge CLOCK) begin
        if (state == ARB_ACCESS && we_q && in_range) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
        end
    end

endmodule
